// File: rtl/dft_accum_pipelined_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dft_accum_pipelined_if                                |
// | Purpose  : sample/oscillator input bus and result-bank handshake |
// |            bus for the pipelined DFT accumulator                 |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface dft_accum_pipelined_if #(
  parameter int IQ_WIDTH           = 16,
  parameter int WINDOW_WIDTH       = 16,
  parameter int OSC_WIDTH          = 27,
  parameter int NUM_BINS           = 24,
  parameter int OUT_WIDTH          = 32,
  parameter int SAMPLE_COUNT_WIDTH = 16
);
  logic                                 start_i;
  logic                                 abort_i;
  logic        [5:0]                    out_shift_i;
  logic                                 sample_valid_i;
  logic                                 last_sample_i;
  logic signed [IQ_WIDTH-1:0]           i_sample_i;
  logic signed [IQ_WIDTH-1:0]           q_sample_i;
  logic signed [WINDOW_WIDTH-1:0]       window_coeff_i;
  logic signed [OSC_WIDTH-1:0]          W_real_i [NUM_BINS];
  logic signed [OSC_WIDTH-1:0]          W_imag_i [NUM_BINS];
  logic signed [OUT_WIDTH-1:0]          A_real_o [NUM_BINS];
  logic signed [OUT_WIDTH-1:0]          A_imag_o [NUM_BINS];
  logic        [NUM_BINS-1:0]           ovf_o;
  logic        [SAMPLE_COUNT_WIDTH-1:0] n_samples_o;
  logic                                 valid_o;
  logic                                 ready_i;
  logic                                 busy_o;

  // Producer/consumer side
  modport master (
    output start_i, abort_i, out_shift_i, sample_valid_i, last_sample_i,
           i_sample_i, q_sample_i, window_coeff_i, W_real_i, W_imag_i, ready_i,
    input  A_real_o, A_imag_o, ovf_o, n_samples_o, valid_o, busy_o
  );

  // Accumulator side
  modport slave (
    input  start_i, abort_i, out_shift_i, sample_valid_i, last_sample_i,
           i_sample_i, q_sample_i, window_coeff_i, W_real_i, W_imag_i, ready_i,
    output A_real_o, A_imag_o, ovf_o, n_samples_o, valid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/dft_accum_pipelined.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dft_accum_pipelined                                   |
// | Purpose  : streaming windowed DFT accumulator, all bins updated  |
// |            in parallel through a 2-stage multiply pipeline into  |
// |            saturating accumulators, with a scaled result bank    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module dft_accum_pipelined #(
  parameter int IQ_WIDTH           = 16,
  parameter int WINDOW_WIDTH       = 16,
  parameter int OSC_WIDTH          = 27,
  parameter int NUM_BINS           = 24,
  parameter int ACCUM_WIDTH        = 48,
  parameter int PROD_SHIFT         = 24,
  parameter int OUT_WIDTH          = 32,
  parameter int SAMPLE_COUNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dft_accum_pipelined_if.slave bus
);
  // Windowed sample width, complex product width, saturating-add width and
  // rounding width (wide enough for any 6-bit output shift)
  localparam int XW = IQ_WIDTH + WINDOW_WIDTH;
  localparam int PW = XW + OSC_WIDTH + 1;
  localparam int SW = ((PW > ACCUM_WIDTH) ? PW : ACCUM_WIDTH) + 1;
  localparam int RW = ACCUM_WIDTH + 64;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_DRAIN    = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_t;

  state_t                         state_q;
  logic                           drain_q;
  logic [5:0]                     shift_q;
  logic [SAMPLE_COUNT_WIDTH-1:0]  cnt_q;
  logic [SAMPLE_COUNT_WIDTH-1:0]  nsamp_q;
  logic                           valid_q;
  logic                           s1_valid_q;
  logic                           s2_valid_q;
  logic signed [XW-1:0]           xi_q;
  logic signed [XW-1:0]           xq_q;

  logic w_start;
  logic w_abort;
  logic w_take;
  logic w_load;
  logic w_acc_clr;

  // Full-precision sample * window
  function automatic logic signed [XW-1:0] f_wmul(
    input logic signed [IQ_WIDTH-1:0]     s,
    input logic signed [WINDOW_WIDTH-1:0] w
  );
    logic signed [XW-1:0] se, we;
    se = {{WINDOW_WIDTH{s[IQ_WIDTH-1]}}, s};
    we = {{IQ_WIDTH{w[WINDOW_WIDTH-1]}}, w};
    return se * we;
  endfunction

  // One leg of the complex product: (a*b -/+ c*d) >>> PROD_SHIFT
  function automatic logic signed [PW-1:0] f_cmac(
    input logic signed [XW-1:0]        a,
    input logic signed [OSC_WIDTH-1:0] b,
    input logic signed [XW-1:0]        c,
    input logic signed [OSC_WIDTH-1:0] d,
    input logic                        sub
  );
    logic signed [PW-1:0] ae, be, ce, de, t;
    ae = {{(PW-XW){a[XW-1]}}, a};
    be = {{(PW-OSC_WIDTH){b[OSC_WIDTH-1]}}, b};
    ce = {{(PW-XW){c[XW-1]}}, c};
    de = {{(PW-OSC_WIDTH){d[OSC_WIDTH-1]}}, d};
    t  = sub ? (ae * be - ce * de) : (ae * be + ce * de);
    return t >>> PROD_SHIFT;
  endfunction

  // Saturating accumulate; MSB of the result flags saturation
  function automatic logic [ACCUM_WIDTH:0] f_sat_add(
    input logic signed [ACCUM_WIDTH-1:0] a,
    input logic signed [PW-1:0]          p
  );
    logic signed [SW-1:0] s, mx, mn;
    mx = {{(SW-ACCUM_WIDTH+1){1'b0}}, {(ACCUM_WIDTH-1){1'b1}}};
    mn = ~mx;
    s  = $signed({{(SW-ACCUM_WIDTH){a[ACCUM_WIDTH-1]}}, a}) +
         $signed({{(SW-PW){p[PW-1]}}, p});
    if (s > mx)      return {1'b1, mx[ACCUM_WIDTH-1:0]};
    else if (s < mn) return {1'b1, mn[ACCUM_WIDTH-1:0]};
    else             return {1'b0, s[ACCUM_WIDTH-1:0]};
  endfunction

  // Round-half-up right shift then saturate to OUT_WIDTH; MSB flags saturation
  function automatic logic [OUT_WIDTH:0] f_scale(
    input logic signed [ACCUM_WIDTH-1:0] a,
    input logic [5:0]                    sh
  );
    logic signed [RW-1:0] v, rnd, mx, mn;
    v   = {{(RW-ACCUM_WIDTH){a[ACCUM_WIDTH-1]}}, a};
    rnd = (sh == 6'd0) ? '0 : ({{(RW-1){1'b0}}, 1'b1} << (sh - 6'd1));
    v   = (v + rnd) >>> sh;
    mx  = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    mn  = ~mx;
    if (v > mx)      return {1'b1, mx[OUT_WIDTH-1:0]};
    else if (v < mn) return {1'b1, mn[OUT_WIDTH-1:0]};
    else             return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  // abort outranks everything else, so it also blocks sample capture and bank load
  assign w_start   = (state_q == S_IDLE) && bus.start_i;
  assign w_abort   = (state_q != S_IDLE) && bus.abort_i;
  assign w_take    = (state_q == S_ACCUM) && bus.sample_valid_i && !w_abort;
  assign w_load    = (state_q == S_WAIT_OUT) && (!valid_q || bus.ready_i) && !w_abort;
  assign w_acc_clr = w_start || w_abort;

  // Frame FSM, sample counter, stage-1 multiply and bank handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      drain_q    <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      nsamp_q    <= '0;
      valid_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      xi_q       <= '0;
      xq_q       <= '0;
    end else begin
      s1_valid_q <= w_take;
      s2_valid_q <= s1_valid_q && !w_abort;
      if (w_take) begin
        xi_q <= f_wmul(bus.i_sample_i, bus.window_coeff_i);
        xq_q <= f_wmul(bus.q_sample_i, bus.window_coeff_i);
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
      if (w_load) begin
        valid_q <= 1'b1;
        nsamp_q <= cnt_q;
      end else if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
      if (w_abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (bus.start_i) begin
            state_q <= S_ACCUM;
            shift_q <= bus.out_shift_i;
            cnt_q   <= '0;
          end
          S_ACCUM: if (w_take && bus.last_sample_i) begin
            state_q <= S_DRAIN;
            drain_q <= 1'b0;
          end
          // two cycles let the last sample reach the accumulators
          S_DRAIN: if (drain_q) state_q <= S_WAIT_OUT;
                   else         drain_q <= 1'b1;
          S_WAIT_OUT: if (w_load) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.n_samples_o = nsamp_q;

  for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
    logic signed [OSC_WIDTH-1:0]   wr_q, wi_q;
    logic signed [PW-1:0]          pr_q, pi_q;
    logic signed [ACCUM_WIDTH-1:0] acc_re_q, acc_im_q;
    logic                          ovf_acc_q;
    logic signed [OUT_WIDTH-1:0]   a_re_q, a_im_q;
    logic                          ovf_bank_q;
    logic [ACCUM_WIDTH:0]          w_re_add, w_im_add;
    logic [OUT_WIDTH:0]            w_re_out, w_im_out;

    assign w_re_add = f_sat_add(acc_re_q, pr_q);
    assign w_im_add = f_sat_add(acc_im_q, pi_q);
    assign w_re_out = f_scale(acc_re_q, shift_q);
    assign w_im_out = f_scale(acc_im_q, shift_q);

    // Oscillator captured alongside the sample, then the complex product
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_q <= '0;
        wi_q <= '0;
        pr_q <= '0;
        pi_q <= '0;
      end else begin
        if (w_take) begin
          wr_q <= bus.W_real_i[k];
          wi_q <= bus.W_imag_i[k];
        end
        if (s1_valid_q) begin
          pr_q <= f_cmac(xi_q, wr_q, xq_q, wi_q, 1'b1);
          pi_q <= f_cmac(xi_q, wi_q, xq_q, wr_q, 1'b0);
        end
      end
    end

    // Saturating accumulation with sticky overflow, cleared per frame
    always_ff @(posedge clk_i) begin
      if (rst_i || w_acc_clr) begin
        acc_re_q  <= '0;
        acc_im_q  <= '0;
        ovf_acc_q <= 1'b0;
      end else if (s2_valid_q) begin
        acc_re_q  <= w_re_add[ACCUM_WIDTH-1:0];
        acc_im_q  <= w_im_add[ACCUM_WIDTH-1:0];
        ovf_acc_q <= ovf_acc_q | w_re_add[ACCUM_WIDTH] | w_im_add[ACCUM_WIDTH];
      end
    end

    // Output bank: loaded with scaled results when the frame is handed over
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_re_q     <= '0;
        a_im_q     <= '0;
        ovf_bank_q <= 1'b0;
      end else if (w_load) begin
        a_re_q     <= w_re_out[OUT_WIDTH-1:0];
        a_im_q     <= w_im_out[OUT_WIDTH-1:0];
        ovf_bank_q <= ovf_acc_q | w_re_out[OUT_WIDTH] | w_im_out[OUT_WIDTH];
      end
    end

    assign bus.A_real_o[k] = a_re_q;
    assign bus.A_imag_o[k] = a_im_q;
    assign bus.ovf_o[k]    = ovf_bank_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_dft_accum_pipelined.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_dft_accum_pipelined                                |
// | Purpose  : scoreboard bench for the pipelined DFT accumulator    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_dft_accum_pipelined;
  localparam int     NB   = 24;
  localparam longint AMAX = (64'sd1 <<< 47) - 1;
  localparam longint OMAX = (64'sd1 <<< 31) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  longint          exp_re[$];
  longint          exp_im[$];
  logic [NB-1:0]   exp_ovf[$];
  int              exp_n[$];

  dft_accum_pipelined_if bus ();
  dft_accum_pipelined_if bus24 ();

  dft_accum_pipelined dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  dft_accum_pipelined #(.ACCUM_WIDTH(24)) dut24 (.clk_i(clk), .rst_i(rst), .bus(bus24));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy_o && t < 200) begin tick(); t++; end
    if (t >= 200) check_val("idle_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!bus.valid_o && t < 200) begin tick(); t++; end
    if (t >= 200) check_val(tag, 0, 1);
  endtask

  function automatic longint sat_ref(input longint v, input longint mx, output bit s);
    s = 1'b0;
    if (v > mx)           begin s = 1'b1; return mx; end
    else if (v < -mx - 1) begin s = 1'b1; return -mx - 1; end
    return v;
  endfunction

  function automatic longint scale_ref(input longint a, input int sh, output bit s);
    longint v;
    v = a;
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
    v = v >>> sh;
    return sat_ref(v, OMAX, s);
  endfunction

  // Drive one complete frame and push its reference result
  task automatic drive_frame(input int n, input bit rnd, input logic [5:0] sh, input bit poke);
    longint are[NB], aim[NB];
    longint wr, wi, xi, xq, pr, pi;
    logic [NB-1:0] ovf;
    int iv, qv, wv;
    bit s;
    ovf = '0;
    for (int k = 0; k < NB; k++) begin are[k] = 0; aim[k] = 0; end
    wait_idle();
    // sample offered together with start must be ignored
    bus.start_i = 1'b1; bus.out_shift_i = sh;
    bus.sample_valid_i = 1'b1; bus.last_sample_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int si = 0; si < n; si++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.sample_valid_i = 1'b0; bus.last_sample_i = 1'b1; tick();
        end
        iv = int'($urandom_range(0, 65535)) - 32768;
        qv = int'($urandom_range(0, 65535)) - 32768;
        wv = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        iv = 4096; qv = 0; wv = 1;
      end
      bus.i_sample_i = 16'(iv); bus.q_sample_i = 16'(qv); bus.window_coeff_i = 16'(wv);
      xi = longint'(iv) * wv;
      xq = longint'(qv) * wv;
      for (int k = 0; k < NB; k++) begin
        if (rnd) begin
          wr = longint'($urandom_range(0, 134217727)) - 64'sd67108864;
          wi = longint'($urandom_range(0, 134217727)) - 64'sd67108864;
        end else begin
          wr = 64'sd16777216; wi = 0;
        end
        bus.W_real_i[k] = 27'(wr);
        bus.W_imag_i[k] = 27'(wi);
        pr = (xi * wr - xq * wi) >>> 24;
        pi = (xi * wi + xq * wr) >>> 24;
        are[k] = sat_ref(are[k] + pr, AMAX, s); ovf[k] = ovf[k] | s;
        aim[k] = sat_ref(aim[k] + pi, AMAX, s); ovf[k] = ovf[k] | s;
      end
      bus.sample_valid_i = 1'b1;
      bus.last_sample_i  = (si == n - 1);
      bus.start_i        = poke && (si == n / 2);
      tick();
    end
    bus.sample_valid_i = 1'b0; bus.last_sample_i = 1'b0; bus.start_i = 1'b0;
    exp_n.push_back(n > 65535 ? 65535 : n);
    for (int k = 0; k < NB; k++) begin
      exp_re.push_back(scale_ref(are[k], int'(sh), s)); ovf[k] = ovf[k] | s;
      exp_im.push_back(scale_ref(aim[k], int'(sh), s)); ovf[k] = ovf[k] | s;
    end
    exp_ovf.push_back(ovf);
  endtask

  // Compare the held frame against the scoreboard when the consumer takes it
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_n.size() == 0) begin
        check_val("unexpected_frame", 1, 0);
      end else begin
        check_val("n_samples", bus.n_samples_o, exp_n.pop_front());
        check_val("ovf", bus.ovf_o, exp_ovf.pop_front());
        for (int k = 0; k < NB; k++) begin
          check_val($sformatf("A_real[%0d]", k), bus.A_real_o[k], exp_re.pop_front());
          check_val($sformatf("A_imag[%0d]", k), bus.A_imag_o[k], exp_im.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.abort_i = 0; bus.out_shift_i = 0; bus.sample_valid_i = 0;
    bus.last_sample_i = 0; bus.i_sample_i = 0; bus.q_sample_i = 0; bus.window_coeff_i = 0;
    bus.ready_i = 0;
    bus24.start_i = 0; bus24.abort_i = 0; bus24.out_shift_i = 0; bus24.sample_valid_i = 0;
    bus24.last_sample_i = 0; bus24.i_sample_i = 0; bus24.q_sample_i = 0;
    bus24.window_coeff_i = 0; bus24.ready_i = 0;
    for (int k = 0; k < NB; k++) begin
      bus.W_real_i[k] = 0; bus.W_imag_i[k] = 0;
      bus24.W_real_i[k] = 0; bus24.W_imag_i[k] = 0;
    end

    // Reset state
    repeat (3) tick();
    check_val("rst_valid", bus.valid_o, 0);
    check_val("rst_busy", bus.busy_o, 0);
    check_val("rst_n_samples", bus.n_samples_o, 0);
    check_val("rst_ovf", bus.ovf_o, 0);
    check_val("rst_A_real0", bus.A_real_o[0], 0);
    rst = 1'b0;
    tick();

    // DC frame and result latency
    drive_frame(16, 1'b0, 6'd0, 1'b0);
    tick(); check_val("dc_valid_n1", bus.valid_o, 0);
    tick(); check_val("dc_valid_n2", bus.valid_o, 0);
    tick(); check_val("dc_valid_n3", bus.valid_o, 1);
    check_val("dc_busy_done", bus.busy_o, 0);
    bus.ready_i = 1'b1; tick(); bus.ready_i = 1'b0;
    check_val("dc_valid_fall", bus.valid_o, 0);

    // Back-to-back frames with the consumer stalled
    drive_frame(5, 1'b0, 6'd0, 1'b0);
    drive_frame(7, 1'b1, 6'd4, 1'b0);
    repeat (6) tick();
    check_val("b2b_busy_held", bus.busy_o, 1);
    check_val("b2b_bank_frame1", bus.n_samples_o, 5);
    check_val("b2b_valid_held", bus.valid_o, 1);
    bus.ready_i = 1'b1; tick();
    check_val("b2b_busy_released", bus.busy_o, 0);
    check_val("b2b_bank_frame2", bus.n_samples_o, 7);
    check_val("b2b_valid_reload", bus.valid_o, 1);
    tick();

    // Abort after 5 samples, then a short DC frame
    wait_idle();
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    bus.i_sample_i = 16'sd4096; bus.q_sample_i = 0; bus.window_coeff_i = 16'sd1;
    bus.sample_valid_i = 1'b1;
    repeat (5) tick();
    bus.sample_valid_i = 1'b0;
    bus.abort_i = 1'b1; tick(); bus.abort_i = 1'b0;
    check_val("abort_idle", bus.busy_o, 0);
    check_val("abort_no_output", bus.valid_o, 0);
    drive_frame(3, 1'b0, 6'd0, 1'b0);
    wait_idle();
    repeat (3) tick();

    // Random frames: rounding shift with a stray start, then unscaled
    drive_frame(64, 1'b1, 6'd8, 1'b1);
    drive_frame(20, 1'b1, 6'd0, 1'b0);
    wait_idle();
    repeat (4) tick();
    check_val("scoreboard_empty", exp_n.size(), 0);

    // Reset mid-frame while a result is held
    bus.ready_i = 1'b0;
    drive_frame(4, 1'b0, 6'd0, 1'b0);
    wait_valid("rst_prep_valid");
    wait_idle();
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    bus.sample_valid_i = 1'b1; tick(); tick(); bus.sample_valid_i = 1'b0;
    check_val("pre_rst_busy", bus.busy_o, 1);
    check_val("pre_rst_valid", bus.valid_o, 1);
    rst = 1'b1; tick();
    check_val("midrst_valid", bus.valid_o, 0);
    check_val("midrst_busy", bus.busy_o, 0);
    check_val("midrst_n_samples", bus.n_samples_o, 0);
    check_val("midrst_A_real0", bus.A_real_o[0], 0);
    check_val("midrst_ovf", bus.ovf_o, 0);
    exp_re.delete(); exp_im.delete(); exp_ovf.delete(); exp_n.delete();
    rst = 1'b0; tick();

    // Narrow accumulator saturates instead of wrapping
    bus24.start_i = 1'b1; tick(); bus24.start_i = 1'b0;
    for (int si = 0; si < 4; si++) begin
      bus24.i_sample_i = 16'sh7FFF; bus24.q_sample_i = 0; bus24.window_coeff_i = 16'sh7FFF;
      for (int k = 0; k < NB; k++) begin
        bus24.W_real_i[k] = 27'sh3FFFFFF; bus24.W_imag_i[k] = 0;
      end
      bus24.sample_valid_i = 1'b1; bus24.last_sample_i = (si == 3);
      tick();
    end
    bus24.sample_valid_i = 1'b0; bus24.last_sample_i = 1'b0;
    begin
      int t = 0;
      while (!bus24.valid_o && t < 50) begin tick(); t++; end
      if (t >= 50) check_val("sat24_valid_timeout", 0, 1);
    end
    check_val("sat24_A_real0", bus24.A_real_o[0], 64'sd8388607);
    check_val("sat24_A_real_last", bus24.A_real_o[NB-1], 64'sd8388607);
    check_val("sat24_A_imag0", bus24.A_imag_o[0], 0);
    check_val("sat24_ovf", bus24.ovf_o, 24'hFFFFFF);
    check_val("sat24_n_samples", bus24.n_samples_o, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
